exp1: RTL and testbench
=======================

EXP1 -- requirements
Module: exp1

Interface
REQ-001 The interface SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rstN, input, 1 bit: asynchronous active-low reset.
REQ-004 Port taskMode, input, 1 bit: task select.
- 0: gate task.
- 1: arithmetic task.
REQ-005 Port subtaskMode, input, 2 bits: subtask select within the current task.
REQ-006 Ports a, b, c, inputs, 1 bit each: operand bits.
REQ-007 Ports l1, l2, outputs, 1 bit each: two-input gate results (gate task) or indicator flags (arithmetic task).
REQ-008 Ports x, y, z, outputs, 1 bit each: three-input results (gate task) or arithmetic results (arithmetic task).

Function
REQ-009 All outputs SHALL be registered.
- Outputs update on each rising clk edge from the mode and operand values sampled at that edge.
- Latency is 1 cycle.
REQ-010 Gate task (taskMode=0), l1/l2 by subtaskMode:
- 00: l1=a AND b, l2=a OR b.
- 01: l1=a XOR b, l2=a XNOR b.
- 10: l1=a NAND b, l2=a NOR b.
- 11: l1=NOT a, l2=NOT b.
REQ-011 Gate task, x/y/z for every subtaskMode:
- x=majority(a,b,c).
- y=a XOR b XOR c.
- z=a AND b AND c.
REQ-012 Arithmetic task (taskMode=1), x/y/z by subtaskMode:
- 00, half adder: x=a XOR b (sum), y=a AND b (carry), z=0.
- 01, full adder: x=a XOR b XOR c (sum), y=majority(a,b,c) (carry-out), z=0.
- 10, half subtractor a-b: x=a XOR b (difference), y=(NOT a) AND b (borrow), z=0.
- 11, full subtractor a-b-c: x=a XOR b XOR c (difference), y=((NOT a) AND (b OR c)) OR (b AND c) (borrow-out), z=0.
REQ-013 Arithmetic task flags:
- l1=1 when y=1 for the current subtask (carry/borrow indicator).
- l2=1 when a=b=c=0 (zero-operand indicator).
REQ-014 A mode change SHALL take effect on the first rising edge after the change, with no intermediate output values.
REQ-015 A mode bit that is not a valid 0/1 at a sampling edge SHALL be treated as 0; taskMode=x/z selects the gate task, and subtaskMode=x/z selects 00.
REQ-016 Operands SHALL pass through to the outputs unchanged in the same cycle their mode is sampled; there is no cross-cycle dependency except the pipeline.

Reset
REQ-017 While rstN=0, l1, l2, x, y and z SHALL all be 0, regardless of clk.
REQ-018 Reset assertion SHALL clear all state, including any synchronizer stages, immediately and asynchronously.
REQ-019 After rstN deasserts, the first valid outputs SHALL appear on the first rising edge at which rstN=1.

Configuration
REQ-020 Macro EXP1_INPUT_SYNC_EN SHALL control a synchronizer on the inputs.
- Defined: a two-flop synchronizer is inserted on a, b, c, taskMode and subtaskMode, and latency becomes 3 cycles.
- Undefined: no synchronizer is present, and latency is 1 cycle.

Structure
REQ-021 Package exp1_pkg SHALL hold the shared definitions:
- Task encodings TASK_GATE=0 and TASK_ARITH=1.
- Subtask encodings for each subtask.
- Typedefs for the mode fields.
REQ-022 Combinational function selection SHALL be in one sub-module, exp1_logic_core, containing no state.
- exp1 holds the optional synchronizer, the output registers and the reset.

Verification
REQ-023 Gate task, taskMode=0, subtaskMode=00, a=1, b=0, c=1 -> next edge: l1=0, l2=1, x=1, y=0, z=0.
REQ-024 Full adder, taskMode=1, subtaskMode=01, abc swept 000..111 at 100-unit steps -> x=parity(abc), y=majority, l1=y, l2=1 only for 000, z=0.
REQ-025 Full subtractor, taskMode=1, subtaskMode=11, a=0, b=1, c=1 -> x=0, y=1, l1=1, l2=0.
REQ-026 Reset, rstN pulled low mid-cycle with outputs at nonzero values -> all outputs 0 immediately; first edge after release shows the function of the current inputs.
REQ-027 Invalid modes, taskMode=x and subtaskMode=xx, abc=111 -> treated as gate task subtask 00: l1=1, l2=1, x=1, y=1, z=1.
REQ-028 With EXP1_INPUT_SYNC_EN defined, an input step is applied -> outputs change exactly 3 rising edges later.

Source files
------------

// File: rtl/exp1_pkg.sv
// rtl/exp1_pkg.sv - shared task/subtask encodings and output bundle for exp1
package exp1_pkg;

    typedef enum logic {
        TASK_GATE  = 1'b0,
        TASK_ARITH = 1'b1
    } task_mode_t;

    typedef enum logic [1:0] {
        SUB_00 = 2'b00,
        SUB_01 = 2'b01,
        SUB_10 = 2'b10,
        SUB_11 = 2'b11
    } subtask_mode_t;

    localparam subtask_mode_t GATE_AND_OR   = SUB_00;
    localparam subtask_mode_t GATE_XOR_XNOR = SUB_01;
    localparam subtask_mode_t GATE_NAND_NOR = SUB_10;
    localparam subtask_mode_t GATE_NOT      = SUB_11;

    localparam subtask_mode_t ARITH_HALF_ADD = SUB_00;
    localparam subtask_mode_t ARITH_FULL_ADD = SUB_01;
    localparam subtask_mode_t ARITH_HALF_SUB = SUB_10;
    localparam subtask_mode_t ARITH_FULL_SUB = SUB_11;

    typedef struct packed {
        logic l1;
        logic l2;
        logic x;
        logic y;
        logic z;
    } exp1_out_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/exp1_logic_core.sv
// rtl/exp1_logic_core.sv - stateless gate/arithmetic function selection for exp1
module exp1_logic_core
    import exp1_pkg::*;
(
    input  logic       task_mode,
    input  logic [1:0] subtask_mode,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output exp1_out_t  result
);

    task_mode_t    task_sel;
    subtask_mode_t sub_sel;

    // Only an explicit 1 selects a mode bit; x/z falls to the default 0 path.
    always_comb begin
        task_sel = TASK_GATE;
        if (task_mode == 1'b1) task_sel = TASK_ARITH;
        sub_sel = SUB_00;
        if (subtask_mode[1] == 1'b1) sub_sel = subtask_mode_t'({1'b1, sub_sel[0]});
        if (subtask_mode[0] == 1'b1) sub_sel = subtask_mode_t'({sub_sel[1], 1'b1});
    end

    always_comb begin
        result = '0;
        if (task_sel == TASK_ARITH) begin
            case (sub_sel)
                ARITH_HALF_ADD: begin
                    result.x = a ^ b;
                    result.y = a & b;
                end
                ARITH_FULL_ADD: begin
                    result.x = a ^ b ^ c;
                    result.y = majority3(a, b, c);
                end
                ARITH_HALF_SUB: begin
                    result.x = a ^ b;
                    result.y = ~a & b;
                end
                default: begin
                    result.x = a ^ b ^ c;
                    result.y = (~a & (b | c)) | (b & c);
                end
            endcase
            result.z  = 1'b0;
            result.l1 = result.y;
            result.l2 = ~(a | b | c);
        end else begin
            case (sub_sel)
                GATE_XOR_XNOR: begin
                    result.l1 = a ^ b;
                    result.l2 = ~(a ^ b);
                end
                GATE_NAND_NOR: begin
                    result.l1 = ~(a & b);
                    result.l2 = ~(a | b);
                end
                GATE_NOT: begin
                    result.l1 = ~a;
                    result.l2 = ~b;
                end
                default: begin
                    result.l1 = a & b;
                    result.l2 = a | b;
                end
            endcase
            result.x = majority3(a, b, c);
            result.y = a ^ b ^ c;
            result.z = a & b & c;
        end
    end

endmodule

// File: rtl/exp1.sv
// rtl/exp1.sv - registered gate/arithmetic unit; EXP1_INPUT_SYNC_EN adds a two-flop input synchronizer
module exp1
    import exp1_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic       taskMode,
    input  logic [1:0] subtaskMode,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       l1,
    output logic       l2,
    output logic       x,
    output logic       y,
    output logic       z
);

    logic [5:0] in_raw;
    logic [5:0] in_core;
    exp1_out_t  core_result;

    assign in_raw = {taskMode, subtaskMode, a, b, c};

`ifdef EXP1_INPUT_SYNC_EN
    logic [5:0] sync_q1;
    logic [5:0] sync_q2;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= in_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign in_core = sync_q2;
`else
    assign in_core = in_raw;
`endif

    exp1_logic_core u_core (
        .task_mode    (in_core[5]),
        .subtask_mode (in_core[4:3]),
        .a            (in_core[2]),
        .b            (in_core[1]),
        .c            (in_core[0]),
        .result       (core_result)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            l1 <= 1'b0;
            l2 <= 1'b0;
            x  <= 1'b0;
            y  <= 1'b0;
            z  <= 1'b0;
        end else begin
            l1 <= core_result.l1;
            l2 <= core_result.l2;
            x  <= core_result.x;
            y  <= core_result.y;
            z  <= core_result.z;
        end
    end

endmodule

// File: tb/tb_exp1.sv
// tb/tb_exp1.sv - directed self-checking bench for exp1
module tb_exp1;

`ifdef EXP1_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rstN;
    logic       taskMode;
    logic [1:0] subtaskMode;
    logic       a, b, c;
    logic       l1, l2, x, y, z;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] fa_exp [8];

    exp1 dut (
        .clk         (clk),
        .rstN        (rstN),
        .taskMode    (taskMode),
        .subtaskMode (subtaskMode),
        .a           (a),
        .b           (b),
        .c           (c),
        .l1          (l1),
        .l2          (l2),
        .x           (x),
        .y           (y),
        .z           (z)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        observed = {l1, l2, x, y, z};
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed l1l2xyz=%b expected %b", tag, observed, expected);
        end
    endtask

    task automatic apply(input logic tm, input logic [1:0] sm, input logic [2:0] abc);
        @(negedge clk);
        taskMode    = tm;
        subtaskMode = sm;
        {a, b, c}   = abc;
    endtask

    task automatic settle();
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    initial begin
        fa_exp[0] = 5'b01000;
        fa_exp[1] = 5'b00100;
        fa_exp[2] = 5'b00100;
        fa_exp[3] = 5'b10010;
        fa_exp[4] = 5'b00100;
        fa_exp[5] = 5'b10010;
        fa_exp[6] = 5'b10010;
        fa_exp[7] = 5'b10110;

        rstN        = 1'b0;
        taskMode    = 1'b0;
        subtaskMode = 2'b00;
        {a, b, c}   = 3'b111;
        #5;
        check("reset_initial", 5'b00000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_with_clock", 5'b00000);
        @(negedge clk);
        rstN = 1'b1;

        apply(1'b0, 2'b00, 3'b101); settle(); check("gate_and_or_101", 5'b01100);
        apply(1'b0, 2'b01, 3'b110); settle(); check("gate_xor_xnor_110", 5'b01100);
        apply(1'b0, 2'b10, 3'b000); settle(); check("gate_nand_nor_000", 5'b11000);
        apply(1'b0, 2'b11, 3'b100); settle(); check("gate_not_100", 5'b01010);

        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 2'b01, 3'(i)); settle();
            check($sformatf("full_add_%0d", i), fa_exp[i]);
        end

        apply(1'b1, 2'b11, 3'b011); settle(); check("full_sub_011", 5'b10010);
        apply(1'b1, 2'b00, 3'b110); settle(); check("half_add_110", 5'b10010);
        apply(1'b1, 2'b10, 3'b010); settle(); check("half_sub_010", 5'b10110);
        apply(1'b1, 2'b10, 3'b101); settle(); check("half_sub_101", 5'b00100);

        apply(1'b1, 2'b01, 3'b111);
        if (LAT > 1) repeat (LAT - 1) @(posedge clk);
        #1;
        check("latency_before", 5'b00100);
        @(posedge clk);
        #1;
        check("latency_after", 5'b10110);

        apply(1'bx, 2'bxx, 3'b111); settle(); check("invalid_mode_111", 5'b11111);

        apply(1'b0, 2'b00, 3'b111); settle(); check("pre_reset_ones", 5'b11111);
        #20;
        rstN = 1'b0;
        #1;
        check("async_reset_immediate", 5'b00000);
        apply(1'b0, 2'b00, 3'b101);
        @(posedge clk);
        #1;
        check("reset_held_edge", 5'b00000);
        @(negedge clk);
        rstN = 1'b1;
        settle();
        check("first_after_release", 5'b01100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
